image_downsample: RTL and testbench

IMAGE_DOWNSAMPLE -- requirements
Module: image_downsample

---
 rtl/image_downsample.sv | 125 ++++++++++++
 tb/tb_image_downsample.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/image_downsample.sv
`default_nettype none
// =============================================================================
// Module   : image_downsample
// Brief    : 2x2 block-average downsampler for a raster grayscale stream.
//            Optional macro IMAGE_DOWNSAMPLE_ROUND_EN selects round-half-up.
// Revision : 1.0 - initial release
// =============================================================================
module image_downsample #(
  parameter int WIDTH = 768,
  parameter int DEPTH = 512
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] data,
  output logic       o_vsync,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       frame_done
);

  localparam int c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_RW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_AW   = (c_CW > 1) ? c_CW - 1 : 1;
  localparam int c_HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    EVEN = 2'd2,
    ODD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_col;
  logic [c_RW-1:0]   r_row;
  logic [7:0]        r_hold;
  logic [8:0]        r_lbuf [c_HALF];

  logic              w_accept;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_odd_row;
  logic [c_AW-1:0]   w_addr;
  logic [9:0]        w_sum;
  logic [7:0]        w_avg;

  assign w_accept   = HSYNC && !VSYNC && (r_state != IDLE);
  assign w_col_last = (r_col == c_CW'(WIDTH - 1));
  assign w_row_last = (r_row == c_RW'(DEPTH - 1));
  assign w_odd_row  = (r_state == ODD);
  assign w_addr     = c_AW'(r_col >> 1);
  assign w_sum      = 10'(r_lbuf[w_addr]) + 10'(r_hold) + 10'(data);

`ifdef IMAGE_DOWNSAMPLE_ROUND_EN
  assign w_avg = 8'((w_sum + 10'd2) >> 2);
`else
  assign w_avg = 8'(w_sum >> 2);
`endif

  // Even rows leave horizontal pair sums behind for the odd row below them.
  always_ff @(posedge HCLK) begin
    if (w_accept && !w_odd_row && r_col[0]) begin
      r_lbuf[w_addr] <= 9'(r_hold) + 9'(data);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_hold     <= '0;
      o_vsync    <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      o_vsync    <= VSYNC;
      o_valid    <= 1'b0;
      o_data     <= '0;
      frame_done <= 1'b0;
      if (VSYNC) begin
        // Frame start or mid-frame resync; any pixel this cycle is dropped.
        r_state <= SYNC;
        r_col   <= '0;
        r_row   <= '0;
      end else if (w_accept) begin
        if (!r_col[0]) begin
          r_hold <= data;
        end else if (w_odd_row) begin
          o_valid    <= 1'b1;
          o_data     <= w_avg;
          frame_done <= w_col_last && w_row_last;
        end
        if (w_col_last) begin
          r_col <= '0;
          unique case (r_state)
            ODD: begin
              if (w_row_last) begin
                r_state <= IDLE;
                r_row   <= '0;
              end else begin
                r_state <= EVEN;
                r_row   <= r_row + c_RW'(1);
              end
            end
            default: begin
              r_state <= ODD;
              r_row   <= r_row + c_RW'(1);
            end
          endcase
        end else begin
          r_col <= r_col + c_CW'(1);
          if (r_state == SYNC) begin
            r_state <= EVEN;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_downsample.sv
`default_nettype none
// =============================================================================
// Module   : tb_image_downsample
// Brief    : Self-checking bench for image_downsample at WIDTH=4, DEPTH=4,
//            compared cycle by cycle against a frame-image reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_image_downsample;

  localparam int c_W = 4;
  localparam int c_D = 4;
  localparam int c_N = c_W * c_D;

  logic       HCLK;
  logic       HRESETn;
  logic       VSYNC;
  logic       HSYNC;
  logic [7:0] data;
  logic       o_vsync;
  logic       o_valid;
  logic [7:0] o_data;
  logic       frame_done;

  image_downsample #(.WIDTH(c_W), .DEPTH(c_D)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .VSYNC      (VSYNC),
    .HSYNC      (HSYNC),
    .data       (data),
    .o_vsync    (o_vsync),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .frame_done (frame_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int         errors = 0;
  int         checks = 0;

  // Reference model: the frame as an image plus the index of the next pixel.
  logic [7:0] img [c_N];
  bit         m_armed = 1'b0;
  int         m_k = 0;
  logic [7:0] got_q [$];
  logic [7:0] ref_q [$];
  logic [7:0] pix [c_N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] block_avg(input int r, input int c);
    int s;
    s = img[(r-1)*c_W + c-1] + img[(r-1)*c_W + c] + img[r*c_W + c-1] + img[r*c_W + c];
`ifdef IMAGE_DOWNSAMPLE_ROUND_EN
    return 8'((s + 2) / 4);
`else
    return 8'(s / 4);
`endif
  endfunction

  task automatic step(input logic vs, input logic hs, input logic [7:0] d);
    logic       e_v;
    logic       e_fd;
    logic [7:0] e_d;
    int         r;
    int         c;
    VSYNC = vs; HSYNC = hs; data = d;
    e_v = 1'b0; e_fd = 1'b0; e_d = 8'd0;
    if (vs) begin
      m_armed = 1'b1;
      m_k     = 0;
    end else if (hs && m_armed) begin
      img[m_k] = d;
      r = m_k / c_W;
      c = m_k % c_W;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e_v = 1'b1;
        e_d = block_avg(r, c);
      end
      if (m_k == c_N - 1) begin
        e_fd    = 1'b1;
        m_armed = 1'b0;
      end
      m_k++;
    end
    @(posedge HCLK);
    #1;
    chk("o_vsync", 32'(o_vsync), 32'(vs));
    chk("o_valid", 32'(o_valid), 32'(e_v));
    chk("o_data", 32'(o_data), 32'(e_d));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (o_valid) got_q.push_back(o_data);
  endtask

  // VSYNC pulse then the first n pixels of pix[], with optional random gaps.
  task automatic run_frame(input int n, input int gap_max);
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0 && i > 0) begin
        int g;
        g = $urandom_range(gap_max, 1);
        for (int j = 0; j < g; j++) step(1'b0, 1'b0, 8'($urandom));
      end
      step(1'b0, 1'b1, pix[i]);
    end
    step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < c_N; i++) pix[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < c_N; i++) pix[i] = 8'($urandom);
  endtask

  task automatic reset_check(input string tag);
    #2;
    HRESETn = 1'b0;
    m_armed = 1'b0;
    m_k     = 0;
    #1;
    chk({tag, "_o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_o_data"}, 32'(o_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_o_vsync"}, 32'(o_vsync), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0; data = 8'd0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_o_vsync", 32'(o_vsync), 32'd0);
    HRESETn = 1'b1;
    step(1'b0, 1'b1, 8'd7);

    // Uniform frame of 100, then HSYNC alone must be ignored in IDLE.
    got_q.delete();
    fill_const(8'd100);
    run_frame(c_N, 0);
    chk("flat_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd50);

    // Rounding corner blocks: sums 5 and 6.
    pix = '{8'd1, 8'd1, 8'd1, 8'd2,
            8'd1, 8'd2, 8'd1, 8'd2,
            8'd0, 8'd0, 8'd3, 8'd3,
            8'd0, 8'd1, 8'd3, 8'd2};
    run_frame(c_N, 0);

    // Saturation-free full scale.
    got_q.delete();
    fill_const(8'd255);
    run_frame(c_N, 0);
    foreach (got_q[i]) chk("full_scale", 32'(got_q[i]), 32'd255);

    // Same random image gap-free and with 1-3 cycle gaps.
    fill_rand();
    got_q.delete();
    run_frame(c_N, 0);
    ref_q = got_q;
    got_q.delete();
    run_frame(c_N, 3);
    chk("gap_count", 32'(got_q.size()), 32'(ref_q.size()));
    foreach (ref_q[i]) if (i < got_q.size()) chk("gap_seq", 32'(got_q[i]), 32'(ref_q[i]));

    // Mid-frame resync after 6 pixels, then a full frame.
    fill_rand();
    got_q.delete();
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, pix[i]);
    chk("abort_outputs", 32'(got_q.size()), 32'd1);
    got_q.delete();
    fill_rand();
    run_frame(c_N, 2);
    chk("resync_count", 32'(got_q.size()), 32'd4);

    // Asynchronous reset while outputs are active.
    fill_rand();
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, pix[i]);
    reset_check("arst_valid");
    step(1'b1, 1'b0, 8'd0);
    reset_check("arst_vsync");
    got_q.delete();
    fill_rand();
    run_frame(c_N, 1);
    chk("post_reset_count", 32'(got_q.size()), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
